// File: rtl/tl_rx_reassembly.sv
// tl_rx_reassembly: gathers DLL beats of one TLP into a single wide word,
// checks framing and the header-declared length, extracts the ECRC DW and
// hands the result to the RX TLP buffer over valid/ready.
module tl_rx_reassembly #(
   parameter int BEAT_DW    = 8,
   parameter int MAX_TLP_DW = 40,
   parameter int CNT_W      = $clog2(MAX_TLP_DW + 1)
) (
   input  logic                    clk,
   input  logic                    arst,
   input  logic [32*BEAT_DW-1:0]   dll_tlp,
   input  logic                    dll_sop,
   input  logic                    dll_eop,
   input  logic                    dll_valid,
   input  logic [3:0]              dll_valid_dw,
   output logic                    dll_halt,
   output logic [32*MAX_TLP_DW-1:0] out_tlp,
   output logic [CNT_W-1:0]        out_len_dw,
   output logic                    out_td,
   output logic [31:0]             out_ecrc,
   output logic                    out_malformed,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    overrun_err
);

   localparam int TLP_W  = 32 * MAX_TLP_DW;
   localparam int LANE_W = (BEAT_DW > 1) ? $clog2(BEAT_DW) : 1;

   typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

   state_t             state_reg;
   logic [TLP_W-1:0]   tlp_reg;
   logic [11:0]        total_reg;      // unsaturated DW count of the current TLP
   logic               overflow_reg;
   logic [31:0]        last_dw_reg;    // last valid DW of the most recent written beat
   logic [CNT_W-1:0]   len_reg;
   logic               td_reg;
   logic [31:0]        ecrc_reg;
   logic               malformed_reg;
   logic               valid_reg;
   logic               halt_reg;
   logic               overrun_reg;

   logic [31:0]        beat_dw [BEAT_DW];
   logic               accept;
   logic               start;
   logic               cont;
   logic               early_sop;
   logic               wr_en;
   logic               enter_hold;
   logic [3:0]         vdw;
   logic [11:0]        base;
   logic [TLP_W-1:0]   tlp_next;
   logic [11:0]        total_next;
   logic               overflow_next;
   logic [31:0]        last_dw_next;
   logic [11:0]        hdr_len;
   logic [11:0]        expected_dw;
   logic               hdr_td;
   logic               malformed_next;
   logic [CNT_W-1:0]   len_next;

   genvar gi;

   // Split the beat into DWs; beat DW0 sits in the MSBs.
   generate
      for (gi = 0; gi < BEAT_DW; gi++) begin : g_lane
         assign beat_dw[gi] = dll_tlp[32*(BEAT_DW-gi)-1 -: 32];
      end
   endgenerate

   // Beat classification, write pointer and bookkeeping for the next state.
   always_comb begin
      accept     = dll_valid & ~halt_reg;
      vdw        = (dll_valid_dw == 4'd0 || dll_valid_dw > 4'(BEAT_DW)) ? 4'(BEAT_DW) : dll_valid_dw;
      start      = accept & dll_sop & (state_reg == IDLE);
      cont       = accept & ~dll_sop & (state_reg == COLLECT);
      early_sop  = accept & dll_sop & (state_reg == COLLECT);
      wr_en      = start | cont;
      enter_hold = (wr_en & dll_eop) | early_sop;
      base       = start ? 12'd0 : total_reg;
      total_next = wr_en ? (base + {8'd0, vdw}) : total_reg;
      overflow_next = (start ? 1'b0 : overflow_reg) | (wr_en & (total_next > 12'(MAX_TLP_DW)));
      last_dw_next  = wr_en ? beat_dw[LANE_W'(vdw - 4'd1)] : last_dw_reg;
   end

   // Each stored DW either takes a beat lane, clears on a new sop, or holds.
   generate
      for (gi = 0; gi < MAX_TLP_DW; gi++) begin : g_dw
         logic [11:0] off;
         logic        hit;
         assign off = 12'(gi) - base;
         assign hit = wr_en && (12'(gi) >= base) && (off < {8'd0, vdw});
         assign tlp_next[TLP_W-1-32*gi -: 32] =
            hit   ? beat_dw[off[LANE_W-1:0]] :
            start ? 32'd0 : tlp_reg[TLP_W-1-32*gi -: 32];
      end
   endgenerate

   // Header-declared length versus what actually arrived, using the final register image.
   always_comb begin
      hdr_td  = tlp_next[TLP_W-17];
      hdr_len = (tlp_next[TLP_W-23 -: 10] == 10'd0) ? 12'd1024 : {2'd0, tlp_next[TLP_W-23 -: 10]};
      expected_dw = (tlp_next[TLP_W-3] ? 12'd4 : 12'd3)
                  + (tlp_next[TLP_W-2] ? hdr_len : 12'd0)
                  + {11'd0, hdr_td};
      malformed_next = overflow_next | (expected_dw != total_next) | early_sop;
      len_next = (total_next > 12'(MAX_TLP_DW)) ? CNT_W'(MAX_TLP_DW) : total_next[CNT_W-1:0];
   end

   // Control FSM with registered outputs; the datapath registers simply track their next values.
   always_ff @(posedge clk) begin
      if (arst) begin
         state_reg     <= IDLE;
         tlp_reg       <= '0;
         total_reg     <= '0;
         overflow_reg  <= 1'b0;
         last_dw_reg   <= '0;
         len_reg       <= '0;
         td_reg        <= 1'b0;
         ecrc_reg      <= '0;
         malformed_reg <= 1'b0;
         valid_reg     <= 1'b0;
         halt_reg      <= 1'b0;
         overrun_reg   <= 1'b0;
      end else begin
         tlp_reg      <= tlp_next;
         total_reg    <= total_next;
         overflow_reg <= overflow_next;
         last_dw_reg  <= last_dw_next;
         if (dll_valid && halt_reg)
            overrun_reg <= 1'b1;
         case (state_reg)
            IDLE, COLLECT: begin
               if (enter_hold) begin
                  state_reg     <= HOLD;
                  valid_reg     <= 1'b1;
                  halt_reg      <= 1'b1;
                  len_reg       <= len_next;
                  td_reg        <= hdr_td;
                  ecrc_reg      <= hdr_td ? last_dw_next : 32'd0;
                  malformed_reg <= malformed_next;
               end else if (start) begin
                  state_reg <= COLLECT;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_reg <= IDLE;
                  valid_reg <= 1'b0;
                  halt_reg  <= 1'b0;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign dll_halt      = halt_reg;
   assign out_tlp       = tlp_reg;
   assign out_len_dw    = len_reg;
   assign out_td        = td_reg;
   assign out_ecrc      = ecrc_reg;
   assign out_malformed = malformed_reg;
   assign out_valid     = valid_reg;
   assign overrun_err   = overrun_reg;

endmodule

// File: tb/tb_tl_rx_reassembly.sv
// Testbench for tl_rx_reassembly: drives TLPs as DLL beats, pushes the
// expected bundle to a scoreboard queue, and compares on each handshake.
module tb_tl_rx_reassembly;

   localparam int BEAT_DW    = 8;
   localparam int MAX_TLP_DW = 40;
   localparam int CNT_W      = $clog2(MAX_TLP_DW + 1);
   localparam int TLP_W      = 32 * MAX_TLP_DW;

   logic                  clk = 1'b0;
   logic                  arst;
   logic [32*BEAT_DW-1:0] dll_tlp;
   logic                  dll_sop;
   logic                  dll_eop;
   logic                  dll_valid;
   logic [3:0]            dll_valid_dw;
   logic                  dll_halt;
   logic [TLP_W-1:0]      out_tlp;
   logic [CNT_W-1:0]      out_len_dw;
   logic                  out_td;
   logic [31:0]           out_ecrc;
   logic                  out_malformed;
   logic                  out_valid;
   logic                  out_ready;
   logic                  overrun_err;

   typedef struct packed {
      logic [TLP_W-1:0] tlp;
      logic [CNT_W-1:0] len;
      logic             td;
      logic [31:0]      ecrc;
      logic             mal;
   } exp_t;

   exp_t        sb[$];
   int          tests = 0;
   int          fails = 0;
   int          txn   = 0;
   logic [31:0] pkt [64];

   always #5 clk = ~clk;

   tl_rx_reassembly #(.BEAT_DW(BEAT_DW), .MAX_TLP_DW(MAX_TLP_DW), .CNT_W(CNT_W)) dut (
      .clk(clk), .arst(arst), .dll_tlp(dll_tlp), .dll_sop(dll_sop), .dll_eop(dll_eop),
      .dll_valid(dll_valid), .dll_valid_dw(dll_valid_dw), .dll_halt(dll_halt),
      .out_tlp(out_tlp), .out_len_dw(out_len_dw), .out_td(out_td), .out_ecrc(out_ecrc),
      .out_malformed(out_malformed), .out_valid(out_valid), .out_ready(out_ready),
      .overrun_err(overrun_err)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mk_hdr(input logic [2:0] fmt, input logic td, input logic [9:0] len);
      logic [31:0] h;
      h = $urandom;
      h[31:29] = fmt;
      h[15]    = td;
      h[9:0]   = len;
      return h;
   endfunction

   task automatic fill(input logic [31:0] hdr, input int n);
      pkt[0] = hdr;
      for (int i = 1; i < n; i++) pkt[i] = $urandom;
   endtask

   task automatic push_exp(input int n, input logic mal);
      exp_t e;
      int   m;
      e = '0;
      m = (n > MAX_TLP_DW) ? MAX_TLP_DW : n;
      for (int k = 0; k < m; k++) e.tlp[TLP_W-1-32*k -: 32] = pkt[k];
      e.len  = CNT_W'(m);
      e.td   = pkt[0][15];
      e.ecrc = pkt[0][15] ? pkt[n-1] : 32'd0;
      e.mal  = mal;
      sb.push_back(e);
   endtask

   task automatic drive_beat(input int idx, input int vdw, input logic sop, input logic eop, input logic full_as_zero);
      for (int l = 0; l < BEAT_DW; l++)
         dll_tlp[32*(BEAT_DW-l)-1 -: 32] = (l < vdw) ? pkt[idx+l] : $urandom;
      dll_sop      = sop;
      dll_eop      = eop;
      dll_valid    = 1'b1;
      dll_valid_dw = (full_as_zero && vdw == BEAT_DW) ? 4'd0 : 4'(vdw);
      @(posedge clk); #1;
      dll_valid = 1'b0;
      dll_sop   = 1'b0;
      dll_eop   = 1'b0;
   endtask

   task automatic wait_idle();
      int c;
      c = 0;
      while (dll_halt && c < 50) begin
         @(posedge clk); #1;
         c++;
      end
      if (dll_halt) check("halt_timeout", 64'(dll_halt), 64'd0);
   endtask

   task automatic send(input int n, input logic mal, input logic fz);
      int idx;
      int v;
      idx = 0;
      wait_idle();
      push_exp(n, mal);
      while (idx < n) begin
         v = (n - idx > BEAT_DW) ? BEAT_DW : n - idx;
         drive_beat(idx, v, idx == 0, idx + v >= n, fz);
         idx += v;
      end
      check("halt_after_eop", 64'(dll_halt), 64'd1);
      check("valid_after_eop", 64'(out_valid), 64'd1);
   endtask

   // Scoreboard: compare the delivered bundle on every handshake.
   always @(negedge clk) begin
      exp_t e;
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_out", 64'(out_valid), 64'd0);
         end else begin
            e = sb.pop_front();
            txn++;
            $display("[TB] txn %0d: len=%0d td=%0d ecrc=%08h malformed=%0d dw0=%08h",
                     txn, out_len_dw, out_td, out_ecrc, out_malformed, out_tlp[TLP_W-1 -: 32]);
            check("len", 64'(out_len_dw), 64'(e.len));
            check("td", 64'(out_td), 64'(e.td));
            check("ecrc", 64'(out_ecrc), 64'(e.ecrc));
            check("malformed", 64'(out_malformed), 64'(e.mal));
            for (int k = 0; k < MAX_TLP_DW; k++)
               check($sformatf("tlp_dw%0d", k), 64'(out_tlp[TLP_W-1-32*k -: 32]), 64'(e.tlp[TLP_W-1-32*k -: 32]));
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [TLP_W-1:0] snap;
      int               halt_cnt;

      arst = 1'b1; out_ready = 1'b1;
      dll_tlp = '0; dll_sop = 1'b0; dll_eop = 1'b0; dll_valid = 1'b0; dll_valid_dw = 4'd0;
      repeat (3) @(posedge clk);
      #1 arst = 1'b0;
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_halt", 64'(dll_halt), 64'd0);
      check("rst_len", 64'(out_len_dw), 64'd0);
      check("rst_td", 64'(out_td), 64'd0);
      check("rst_ecrc", 64'(out_ecrc), 64'd0);
      check("rst_malformed", 64'(out_malformed), 64'd0);
      check("rst_overrun", 64'(overrun_err), 64'd0);
      check("rst_tlp_zero", 64'(|out_tlp), 64'd0);

      // 3DW MWr Length=7 TD=1: 8 + 3 DW beats
      fill(mk_hdr(3'b010, 1'b1, 10'd7), 11);
      send(11, 1'b0, 1'b0);

      // 4DW MRd, single beat
      fill(mk_hdr(3'b001, 1'b0, 10'd1), 4);
      send(4, 1'b0, 1'b0);

      // beat without sop in IDLE is silently dropped
      wait_idle();
      fill(32'h0, 3);
      drive_beat(0, 3, 1'b0, 1'b1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("nosop_valid", 64'(out_valid), 64'd0);
      check("nosop_halt", 64'(dll_halt), 64'd0);

      // 3DW MWr Length=7 TD=0 but only 9 DW delivered
      fill(mk_hdr(3'b010, 1'b0, 10'd7), 9);
      send(9, 1'b1, 1'b0);

      // 4DW MWr Length=40: 44 DW overflow the register; full beats use valid_dw=0
      fill(mk_hdr(3'b011, 1'b0, 10'd40), 44);
      send(44, 1'b1, 1'b1);

      // back-pressure with a beat arriving during HOLD
      wait_idle();
      out_ready = 1'b0;
      fill(mk_hdr(3'b010, 1'b1, 10'd5), 9);
      send(9, 1'b0, 1'b0);
      snap = out_tlp;
      halt_cnt = 1;
      for (int i = 1; i < 8; i++) begin
         if (i == 1) begin
            dll_tlp = {BEAT_DW{$urandom}};
            dll_sop = 1'b1; dll_eop = 1'b1; dll_valid_dw = 4'd1; dll_valid = 1'b1;
         end
         @(posedge clk); #1;
         dll_valid = 1'b0; dll_sop = 1'b0; dll_eop = 1'b0;
         if (dll_halt) halt_cnt++;
         if (!out_ready) check("tlp_stable", 64'(out_tlp == snap), 64'd1);
         if (i == 5) out_ready = 1'b1;
      end
      check("halt_cycles", 64'(halt_cnt), 64'd6);
      check("overrun_set", 64'(overrun_err), 64'd1);
      check("halt_released", 64'(dll_halt), 64'd0);

      // new sop before eop: partial TLP delivered malformed, new sop beat dropped
      wait_idle();
      fill(mk_hdr(3'b010, 1'b1, 10'd7), 11);
      push_exp(8, 1'b1);
      drive_beat(0, 8, 1'b1, 1'b0, 1'b0);
      drive_beat(8, 3, 1'b1, 1'b0, 1'b0);
      check("early_halt", 64'(dll_halt), 64'd1);
      check("early_valid", 64'(out_valid), 64'd1);
      wait_idle();
      check("overrun_sticky", 64'(overrun_err), 64'd1);

      // reset in the middle of COLLECT, then a fresh single-beat TLP
      fill(mk_hdr(3'b010, 1'b1, 10'd7), 11);
      drive_beat(0, 8, 1'b1, 1'b0, 1'b0);
      arst = 1'b1;
      @(posedge clk); #1;
      arst = 1'b0;
      check("abort_valid", 64'(out_valid), 64'd0);
      check("abort_halt", 64'(dll_halt), 64'd0);
      check("abort_overrun", 64'(overrun_err), 64'd0);
      fill(mk_hdr(3'b010, 1'b0, 10'd4), 7);
      send(7, 1'b0, 1'b0);

      repeat (5) @(posedge clk);
      #1;
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/tl_rx_reassembly.md
# tl_rx_reassembly

Receive-side counterpart of the TX fragmentation path. It accepts a TLP from the Data Link Layer as a stream of DLL-width beats framed by sop/eop with per-beat valid-DW counts. It reassembles the beats into one wide TLP word and hands that word to the RX TLP buffer over a valid/ready handshake. The block checks framing and header-declared length, extracts the ECRC DW, and back-pressures the DLL while a completed TLP waits for the buffer.

## Interface
- BEAT_DW, 8, DWs per DLL beat (beat width = 32*BEAT_DW bits).
- MAX_TLP_DW, 40, capacity of the reassembly register in DW (header, payload and ECRC).
- CNT_W, $clog2(MAX_TLP_DW+1), width of DW counters.
- clk  in  1  single clock; all logic on rising edge.
- arst  in  1  reset, synchronous, active-high; clears all state and outputs listed below.
- dll_tlp  in  32*BEAT_DW  beat data; first DW of the beat in the MSBs.
- dll_sop  in  1  first beat of a TLP.
- dll_eop  in  1  last beat of a TLP (may coincide with sop).
- dll_valid  in  1  beat present this cycle.
- dll_valid_dw  in  4  valid DWs in the beat, 1..BEAT_DW, MSB-aligned; 0 or >BEAT_DW is treated as BEAT_DW.
- dll_halt  out  1  back-pressure to DLL; when 1 the DLL must not present beats.
- out_tlp  out  32*MAX_TLP_DW  reassembled TLP; DW0 in the MSBs, unused DWs zero.
- out_len_dw  out  CNT_W  DWs stored (saturates at MAX_TLP_DW).
- out_td  out  1  TD bit of header DW0.
- out_ecrc  out  32  last received DW when out_td=1, else 0.
- out_malformed  out  1  framing, length or overflow error for this TLP.
- out_valid  out  1  out_* bundle valid.
- out_ready  in  1  RX buffer accepts the bundle.
- overrun_err  out  1  sticky; a beat arrived while dll_halt=1. Cleared only by arst.

## Operation
- States: IDLE, COLLECT, HOLD. After arst: IDLE, with every output 0.
- Beat accepted = dll_valid & ~dll_halt. Beats that arrive while dll_halt=1 are discarded and set overrun_err.
- IDLE, accepted beat without sop: discard the beat and stay in IDLE; this is not an error.
- IDLE, accepted beat with sop: clear the register and write the beat at DW offset 0. Set wr_ptr = valid_dw.
  - If eop is also set: go to HOLD.
  - Otherwise: go to COLLECT.
- COLLECT, accepted beat: write its valid DWs at wr_ptr and advance wr_ptr.
  - Any DW whose index would be ≥ MAX_TLP_DW is dropped, and a sticky overflow flag is set.
  - If eop is set: go to HOLD.
- COLLECT, accepted beat with sop (new TLP before eop): the partial TLP is delivered malformed.
  - Go to HOLD with out_malformed=1.
  - The new sop beat is discarded.
- HOLD: out_valid=1 and dll_halt=1. When out_ready=1, go to IDLE.
- Length check, evaluated on entry to HOLD from header DW0 = out_tlp[32*MAX_TLP_DW-1 -: 32]:
  - expected = (fmt[29]?4:3) + (fmt[30] ? (Length[9:0]==0 ? 1024 : Length) : 0) + TD[15].
  - Compute expected in 12 bits.
  - out_malformed = overflow | (expected != total received DW) | early-sop.
  - Total received DW is counted unsaturated in 12 bits.
- out_ecrc: at eop, capture the DW at beat index valid_dw-1 (masked to 0 if TD=0). For a TLP shorter than one beat, use the final valid DW.
- out_len_dw = min(total received, MAX_TLP_DW).

## Timing
- The eop beat is accepted at edge N; out_valid=1 and dll_halt=1 from edge N+1.
- Handshake: transfer occurs on an edge with out_valid & out_ready. out_valid and dll_halt drop on the following cycle.
- dll_halt is a registered state decode (state==HOLD), so the DLL sees it one cycle after eop. The DLL must not drive a new beat in the cycle immediately after eop while dll_halt=1.
- Minimum spacing between TLP eop and next sop is 2 cycles (HOLD with out_ready tied 1, then IDLE).
- out_* hold steady throughout HOLD.
- arst during COLLECT or HOLD discards the TLP and returns to IDLE next cycle. arst does not pulse out_valid.
- Throughput: one beat per cycle in COLLECT; no internal bubbles.

## Test plan
- 3DW MWr, Length=7, TD=1 (11 DW): sop beat valid_dw=8, then eop beat valid_dw=3 -> out_valid 1 cycle after eop; out_len_dw=11, out_td=1, out_ecrc=DW10, out_malformed=0, DW0 at out_tlp MSBs.
- 4DW MRd (fmt=3'b001), single beat sop+eop valid_dw=4 -> out_len_dw=4, out_malformed=0, out_ecrc=0.
- 3DW MWr with Length=7, TD=0, delivered as 9 DW -> out_malformed=1, out_len_dw=9.
- MWr Length=40 (4DW header, 44 DW sent over 6 beats) -> out_len_dw=40, out_malformed=1, no write beyond DW39.
- Backpressure: hold out_ready=0 for 5 cycles after eop; drive a beat during HOLD -> dll_halt=1 for 6 cycles, out_tlp stable, overrun_err=1 and stays 1. Then out_ready=1 -> return to IDLE, dll_halt=0 next cycle.
- arst=1 for one cycle mid-COLLECT, then a fresh 1-beat TLP -> no out_valid for the aborted TLP; the fresh TLP is delivered correctly with out_malformed=0.
